// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = 3
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_is_mul;
  logic                  ex_branch_taken;
  logic                  imem_busy;
  logic                  dmem_busy;

  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_flush;
  logic                  mem_wb_flush;
  logic [15:0]           stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_is_mul, ex_branch_taken, imem_busy, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_is_mul, ex_branch_taken, imem_busy, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline stall/flush controller with multi-cycle multiply wait.
// Optional stall performance counter enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int REG_ADDR_W = 3
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);
  localparam int              CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  load_use;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  assign load_use = bus.ex_mem_read &&
                    ((bus.id_use_rs1 && (rs1 == rd)) ||
                     (bus.id_use_rs2 && (rs2 == rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority chain: reset, dmem_busy, multiply, branch, load-use, imem_busy.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    if (reset) begin
      state_d      = RUN;
      cnt_d        = '0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (bus.dmem_busy) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (state_q == MUL_WAIT) begin
      // Branch and load-use are meaningless while EX is occupied by the multiply.
      if (cnt_q != '0) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        cnt_d        = cnt_q - CNT_ONE;
      end else begin
        state_d = RUN;
      end
    end else if (bus.ex_is_mul) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      cnt_d        = CNT_LOAD;
      state_d      = MUL_WAIT;
    end else if (bus.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.imem_busy) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 16'd0;
`endif
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, the number of cycles a multiply occupies EX; legal range 2..16.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, the register-address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs1, id_rs2  input  REG_ADDR_W  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  input  1  the ID instruction reads rs1 / rs2.
REQ-007 ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
REQ-008 ex_mem_read  input  1  the EX instruction is a load.
REQ-009 ex_is_mul  input  1  the EX instruction is a multi-cycle multiply (level).
REQ-010 ex_branch_taken  input  1  a branch or jump resolved taken in EX.
REQ-011 imem_busy  input  1  the instruction fetch is not complete this cycle.
REQ-012 dmem_busy  input  1  the data-memory access in MEM is not complete this cycle.
REQ-013 pc_en  output  1  PC update enable.
REQ-014 if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline-register enables (0 = hold).
REQ-015 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  pipeline-register flush (load bubble).
REQ-016 stall_cycles  output  16  performance counter (see Configuration).

Function
REQ-017 All control outputs SHALL be combinational from the current state, the counter and the inputs, with zero-cycle latency to the pipeline registers.
REQ-018 States SHALL be RUN and MUL_WAIT, and the block SHALL hold a multiply counter of width clog2(MUL_CYCLES).
REQ-019 Default (no event): all *_en=1, all *_flush=0.
REQ-020 Priority, highest first: dmem_busy, multiply, branch, load-use, imem_busy.
REQ-021 dmem_busy=1 SHALL set all *_en=0 and all *_flush=0, and the state and counter SHALL hold in any state.
REQ-022 In RUN with ex_is_mul=1: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1; counter loads MUL_CYCLES-2; next state MUL_WAIT.
REQ-023 In MUL_WAIT with counter!=0: same outputs as REQ-022; counter decrements.
REQ-024 In MUL_WAIT with counter==0: default outputs; next state RUN; total EX residency is exactly MUL_CYCLES cycles.
REQ-025 In MUL_WAIT, ex_branch_taken and the load-use condition SHALL be ignored.
REQ-026 Branch (RUN, ex_branch_taken=1): pc_en=1, if_id_flush=1, id_ex_flush=1; branch overrides load-use and imem_busy.
REQ-027 Load-use hazard = ex_mem_read && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-028 In RUN, a load-use hazard SHALL set pc_en=0, if_id_en=0 and id_ex_flush=1 for one cycle; the hazard clears naturally on the next cycle.
REQ-029 imem_busy (RUN, no higher event): pc_en=0, if_id_flush=1; other stages advance.
REQ-030 A flush output and the enable of the same register SHALL never be asserted together as 0 and 1 in conflict; flush wins when both are asserted.

Reset
REQ-031 While reset=1: state=RUN, counter=0, stall_cycles=0, all *_en=0, all *_flush=1.
REQ-032 Reset asserted in MUL_WAIT SHALL abort the multiply wait; the first cycle after reset SHALL be RUN with default outputs when no inputs are active.

Configuration
REQ-033 Macro PIPE_PERF_CNT_EN defined: stall_cycles SHALL increment each non-reset cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-034 PIPE_PERF_CNT_EN undefined: stall_cycles SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-035 Load r2 in EX (ex_rd=2, ex_mem_read=1), ID reads rs1=2 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then defaults.
REQ-036 ex_is_mul=1 with MUL_CYCLES=4 -> 3 cycles with front stalled and ex_mem_flush=1, 4th cycle defaults, state back to RUN.
REQ-037 ex_branch_taken=1 together with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall.
REQ-038 dmem_busy=1 for 3 cycles during MUL_WAIT with counter=1 -> all en=0 and counter held at 1 across those cycles; after release, 1 more stall cycle, then RUN.
REQ-039 reset=1 mid-MUL_WAIT -> all en=0, all flush=1 during reset; next cycle RUN, default outputs.
REQ-040 With PIPE_PERF_CNT_EN, 5 load-use stalls plus a 4-cycle multiply -> stall_cycles=8; without the macro -> stall_cycles=0.
